// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline boundary register: main + skid entry with a registered in_ready,
// synchronous flush on redirect. Define IF_ID_STALL_CNT_EN to add the stall_cnt port.
module if_id_stage_reg #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
`ifdef IF_ID_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
);

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     m_pc_q, m_pc_d, s_pc_q;
    logic [INST_W-1:0]   m_inst_q, m_inst_d, s_inst_q;
    logic                m_load, s_load, m_from_skid;
    logic                accept, drain;

    // Both handshake flags come straight from state flops, so no ready path crosses the stage.
    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign out_pc    = out_valid ? m_pc_q : '0;
    assign out_inst  = out_valid ? m_inst_q : NOP_INST;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        m_load      = 1'b0;
        s_load      = 1'b0;
        m_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                    m_load  = 1'b1;
                end
            end
            FULL: begin
                if (accept && drain) begin
                    m_load = 1'b1;
                end else if (accept) begin
                    state_d = SKID;
                    s_load  = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                if (drain) begin
                    state_d     = FULL;
                    m_load      = 1'b1;
                    m_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Redirect wins over everything; the flush-cycle input is dropped and no data reg loads.
        if (flush) begin
            state_d = EMPTY;
            m_load  = 1'b0;
            s_load  = 1'b0;
        end
    end

    always_comb begin
        m_pc_d   = m_from_skid ? s_pc_q   : in_pc;
        m_inst_d = m_from_skid ? s_inst_q : in_inst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Data regs are enable-only: they never load unless a move actually happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc_q   <= '0;
            m_inst_q <= NOP_INST;
            s_pc_q   <= '0;
            s_inst_q <= NOP_INST;
        end else begin
            if (m_load) begin
                m_pc_q   <= m_pc_d;
                m_inst_q <= m_inst_d;
            end
            if (s_load) begin
                s_pc_q   <= in_pc;
                s_inst_q <= in_inst;
            end
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: directed scenarios plus random traffic against a
// 2-deep FIFO reference model of the stage.
module tb_if_id_stage_reg;

    logic        clk, rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_pc, in_inst, out_pc, out_inst;
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    if_id_stage_reg dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_inst  (in_inst),
        .flush    (flush),
`ifdef IF_ID_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_inst (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: ordered list of held {pc, inst}, at most two deep.
    logic [63:0] q[$];
    int unsigned stall_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] e_pc, e_inst;
        e_pc   = (q.size() > 0) ? q[0][63:32] : 32'h0;
        e_inst = (q.size() > 0) ? q[0][31:0]  : 32'h00000013;
        chk({tag, ".vld"},  {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk({tag, ".pc"},   out_pc, e_pc);
        chk({tag, ".inst"}, out_inst, e_inst);
        chk({tag, ".rdy"},  {31'b0, in_ready}, {31'b0, q.size() < 2});
`ifdef IF_ID_STALL_CNT_EN
        chk({tag, ".stall"}, stall_cnt, stall_m);
`endif
    endtask

    // Drive one cycle's inputs, advance the model across the edge, check at negedge.
    task automatic cycle(input string tag, input logic iv, input logic [31:0] pc,
                         input logic [31:0] inst, input logic ordy, input logic fl);
        logic acc, drn;
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        if ((q.size() > 0) && !ordy && stall_m != 32'hFFFF_FFFF) stall_m++;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back({pc, inst});
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return (pc << 7) ^ 32'h0000_1033;
    endfunction

    initial begin
        logic [31:0] pc_hold, inst_hold;
        rst = 1'b1; in_valid = 0; in_pc = 0; in_inst = 0; flush = 0; out_ready = 0;
        #2;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back streaming, no bubbles.
        for (int i = 0; i < 4; i++)
            cycle("stream", 1'b1, 32'(i * 4), mk_inst(32'(i * 4)), 1'b1, 1'b0);
        cycle("stream_tail", 1'b0, 0, 0, 1'b1, 1'b0);

        // Fill main + skid, then drain in order.
        cycle("fill0", 1'b1, 32'h10, mk_inst(32'h10), 1'b0, 1'b0);
        cycle("fill1", 1'b1, 32'h14, mk_inst(32'h14), 1'b0, 1'b0);
        cycle("fill_blk", 1'b1, 32'h18, mk_inst(32'h18), 1'b0, 1'b0);
        cycle("drain0", 1'b0, 0, 0, 1'b1, 1'b0);
        cycle("drain1", 1'b0, 0, 0, 1'b1, 1'b0);

        // Flush in SKID drops everything, including the flush-cycle input.
        cycle("sk0", 1'b1, 32'h30, mk_inst(32'h30), 1'b0, 1'b0);
        cycle("sk1", 1'b1, 32'h34, mk_inst(32'h34), 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'h40, mk_inst(32'h40), 1'b0, 1'b1);
        cycle("post_flush", 1'b1, 32'h80, mk_inst(32'h80), 1'b0, 1'b0);
        cycle("post_flush_drn", 1'b0, 0, 0, 1'b1, 1'b0);

        // Held entry under back-pressure stays constant.
        cycle("hold_ld", 1'b1, 32'h200, mk_inst(32'h200), 1'b0, 1'b0);
        pc_hold = out_pc; inst_hold = out_inst;
        for (int i = 0; i < 5; i++) cycle("hold", 1'b0, 0, 0, 1'b0, 1'b0);
        chk("hold_pc", out_pc, pc_hold);
        chk("hold_inst", out_inst, inst_hold);
`ifdef IF_ID_STALL_CNT_EN
        chk("hold_stall_delta", stall_cnt - stall_m, 0);
`endif
        cycle("hold_drn", 1'b0, 0, 0, 1'b1, 1'b0);

        // Asynchronous reset while in SKID.
        cycle("rs0", 1'b1, 32'h50, mk_inst(32'h50), 1'b0, 1'b0);
        cycle("rs1", 1'b1, 32'h54, mk_inst(32'h54), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        q.delete();
        stall_m = 0;
        chk("rst_vld", {31'b0, out_valid}, 32'h0);
        chk("rst_inst", out_inst, 32'h00000013);
        chk("rst_rdy", {31'b0, in_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        cycle("rst_acc", 1'b1, 32'h100, mk_inst(32'h100), 1'b0, 1'b0);
        chk("rst_acc_pc", out_pc, 32'h100);
        cycle("rst_drn", 1'b0, 0, 0, 1'b1, 1'b0);

        // Random traffic with ~10% flush rate.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] rpc;
            rpc = {$urandom_range(32'hFFFF), 2'b00} + 32'h1000;
            cycle("rand", ($urandom_range(3) != 0), rpc, $urandom(),
                  ($urandom_range(2) != 0), ($urandom_range(9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
